tc_counter_gen: RTL and testbench

Generator side of the counter / terminal-flag interface. Drives a WIDTH-bit count and a terminal flag t such that t is high exactly when count equals MAX_VAL, in the same cycle. Adds start/stop control, one-shot or auto-reload modes and a wrap counter. Sits upstream of the count/terminal-flag property checker and must satisfy it on every clock edge.

---
 rtl/tc_counter_gen_if.sv | 28 ++
 rtl/tc_counter_gen.sv | 102 ++++++++++
 tb/tb_tc_counter_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/tc_counter_gen_if.sv
// Control and status bundle between a counter controller (master) and
// tc_counter_gen (slave).
interface tc_counter_gen_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic              clear;
  logic              start;
  logic              stop;
  logic              en;
  logic              auto_reload;
  logic [WIDTH-1:0]  init_val;
  logic [WIDTH-1:0]  count;
  logic              t;
  logic              busy;
  logic              done;
  logic [WRAP_W-1:0] wraps;

  modport master (
    output clear, start, stop, en, auto_reload, init_val,
    input  count, t, busy, done, wraps
  );

  modport slave (
    input  clear, start, stop, en, auto_reload, init_val,
    output count, t, busy, done, wraps
  );
endinterface

// File: rtl/tc_counter_gen.sv
// Count / terminal-flag generator: start/stop control, one-shot or
// auto-reload operation and a saturating wrap counter.
module tc_counter_gen #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 15,
  parameter int WRAP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  tc_counter_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0]  MAX_C    = WIDTH'(MAX_VAL);
  localparam logic [WRAP_W-1:0] WRAP_SAT = {WRAP_W{1'b1}};

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              t_q, t_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state, next-count and flag computation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wraps_d = wraps_q;
    if (bus.clear) begin
      state_d = ST_IDLE;
      count_d = {WIDTH{1'b0}};
      wraps_d = {WRAP_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            count_d = (bus.init_val > MAX_C) ? MAX_C : bus.init_val;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // start is ignored while running, so stop alone decides here.
          if (bus.stop) begin
            state_d = ST_IDLE;
          end else if (bus.en) begin
            if (count_q < MAX_C) begin
              count_d = count_q + WIDTH'(1);
            end else if (bus.auto_reload) begin
              count_d = {WIDTH{1'b0}};
              wraps_d = (wraps_q == WRAP_SAT) ? wraps_q : wraps_q + WRAP_W'(1);
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            count_d = count_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // t is derived from the next count so it lands in the same register
    // update as count and can never disagree with it.
    t_d    = (count_d == MAX_C);
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= {WIDTH{1'b0}};
      wraps_q <= {WRAP_W{1'b0}};
      t_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wraps_q <= wraps_d;
      t_q     <= t_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.t     = t_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.wraps = wraps_q;

endmodule

// File: tb/tb_tc_counter_gen.sv
// Self-checking bench for tc_counter_gen: cycle model plus directed scenarios.
module tb_tc_counter_gen;

  localparam int WIDTH   = 4;
  localparam int MAX_VAL = 15;
  localparam int WRAP_W  = 8;
  localparam int WRAP_MAX = (1 << WRAP_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  tc_counter_gen_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

  tc_counter_gen #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .WRAP_W(WRAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int wraps;
    bit running;
    bit done;
  } model_t;

  model_t m = '{cnt: 0, wraps: 0, running: 1'b0, done: 1'b0};

  function automatic model_t next_model(model_t cur, bit clr, bit st, bit sp,
                                        bit e, bit ar, int iv);
    model_t n = cur;
    n.done = 1'b0;
    if (clr) begin
      n.cnt = 0; n.wraps = 0; n.running = 1'b0;
    end else if (!cur.running) begin
      if (st) begin
        n.running = 1'b1;
        n.cnt = (iv > MAX_VAL) ? MAX_VAL : iv;
      end
    end else if (sp) begin
      n.running = 1'b0;
    end else if (e) begin
      if (cur.cnt < MAX_VAL) n.cnt = cur.cnt + 1;
      else if (ar) begin
        n.cnt = 0;
        if (cur.wraps < WRAP_MAX) n.wraps = cur.wraps + 1;
      end else begin
        n.running = 1'b0;
        n.done = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{cnt: 0, wraps: 0, running: 1'b0, done: 1'b0};
    else     m <= next_model(m, bus.clear, bus.start, bus.stop, bus.en,
                             bus.auto_reload, int'(bus.init_val));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT against model, plus the terminal-flag invariant itself.
  always @(negedge clk) begin
    chk("model_count", 32'(bus.count), 32'(m.cnt));
    chk("model_t",     32'(bus.t),     32'(m.cnt == MAX_VAL));
    chk("model_busy",  32'(bus.busy),  32'(m.running));
    chk("model_done",  32'(bus.done),  32'(m.done));
    chk("model_wraps", 32'(bus.wraps), 32'(m.wraps));
    chk("invariant_t", 32'(bus.t),     32'(bus.count == WIDTH'(MAX_VAL)));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit clr, input bit st, input bit sp, input bit e,
                       input bit ar, input int iv);
    bus.clear = clr; bus.start = st; bus.stop = sp; bus.en = e;
    bus.auto_reload = ar; bus.init_val = WIDTH'(iv);
  endtask

  task automatic expect_out(input string tag, input int c, input int tt,
                            input int b, input int d, input int w);
    chk({tag, "_count"}, 32'(bus.count), 32'(c));
    chk({tag, "_t"},     32'(bus.t),     32'(tt));
    chk({tag, "_busy"},  32'(bus.busy),  32'(b));
    chk({tag, "_done"},  32'(bus.done),  32'(d));
    chk({tag, "_wraps"}, 32'(bus.wraps), 32'(w));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    tick(2);
    expect_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(1);
    expect_out("post_reset", 0, 0, 0, 0, 0);

    // One-shot from 0.
    drive(0, 1, 0, 1, 0, 0);
    tick(1);
    expect_out("os_start", 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    tick(14);
    expect_out("os_14", 14, 0, 1, 0, 0);
    tick(1);
    expect_out("os_15", 15, 1, 1, 0, 0);
    tick(1);
    expect_out("os_done", 15, 1, 0, 1, 0);
    tick(1);
    expect_out("os_idle", 15, 1, 0, 0, 0);

    // Auto-reload for 40 counted cycles.
    drive(0, 1, 0, 1, 1, 0);
    tick(1);
    drive(0, 0, 0, 1, 1, 0);
    tick(39);
    expect_out("ar_40", 7, 0, 1, 0, 2);
    drive(0, 0, 1, 1, 1, 0);
    tick(1);
    expect_out("ar_stop", 7, 0, 0, 0, 2);

    // init 13 with en pattern 1,0,1,1.
    drive(0, 1, 0, 0, 0, 13);
    tick(1);
    expect_out("en_13", 13, 0, 1, 0, 2);
    drive(0, 0, 0, 1, 0, 0); tick(1);
    expect_out("en_14a", 14, 0, 1, 0, 2);
    drive(0, 0, 0, 0, 0, 0); tick(1);
    expect_out("en_14b", 14, 0, 1, 0, 2);
    drive(0, 0, 0, 1, 0, 0); tick(1);
    expect_out("en_15", 15, 1, 1, 0, 2);
    tick(1);
    expect_out("en_done", 15, 1, 0, 1, 2);

    // Restart directly from DONE reloads.
    drive(0, 1, 0, 1, 0, 5);
    tick(1);
    expect_out("done_restart", 5, 0, 1, 0, 2);
    drive(0, 0, 0, 1, 0, 0);
    tick(4);
    expect_out("ss_9", 9, 0, 1, 0, 2);
    drive(0, 1, 1, 1, 0, 2);
    tick(1);
    expect_out("ss_stop", 9, 0, 0, 0, 2);
    drive(0, 0, 0, 1, 0, 0);
    tick(2);
    expect_out("ss_hold", 9, 0, 0, 0, 2);

    // Clear at terminal count while auto-reloading.
    drive(0, 1, 0, 1, 1, 12);
    tick(1);
    drive(0, 0, 0, 1, 1, 0);
    tick(3);
    expect_out("clr_pre", 15, 1, 1, 0, 2);
    drive(1, 1, 1, 1, 1, 0);
    tick(1);
    expect_out("clr", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    tick(1);
    expect_out("clr_after", 0, 0, 0, 0, 0);

    // Wrap counter saturation.
    drive(0, 1, 0, 1, 1, 0);
    tick(1);
    drive(0, 0, 0, 1, 1, 0);
    tick(16 * (WRAP_MAX + 5));
    expect_out("sat", 0, 0, 1, 0, WRAP_MAX);
    drive(1, 0, 0, 0, 0, 0);
    tick(1);
    expect_out("sat_clr", 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a run.
    drive(0, 1, 0, 1, 0, 0);
    tick(1);
    drive(0, 0, 0, 1, 0, 0);
    tick(6);
    expect_out("ar_pre", 6, 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 0, 0, 0, 0, 0);
    tick(2);
    rst = 1'b0;
    tick(3);
    expect_out("rst_release", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
